// File: rtl/mac_fwd_engine_if.sv
// rtl/mac_fwd_engine_if.sv - header request / forwarding decision handshake bundle
interface mac_fwd_engine_if #(
    parameter int NUM_PORTS = 4
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [47:0]          req_src_mac;
    logic [47:0]          req_dst_mac;
    logic [PORT_W-1:0]    req_port;
    logic                 req_frame_valid;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [NUM_PORTS-1:0] rsp_port_mask;

    modport master (
        output req_valid, req_src_mac, req_dst_mac, req_port, req_frame_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_port_mask
    );

    modport slave (
        input  req_valid, req_src_mac, req_dst_mac, req_port, req_frame_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_port_mask
    );
endinterface

// File: rtl/mac_fwd_engine.sv
// rtl/mac_fwd_engine.sv - L2 MAC learning table with aging and per-frame egress mask decision
module mac_fwd_engine #(
    parameter int NUM_PORTS   = 4,
    parameter int TABLE_DEPTH = 8,
    parameter int AGE_MAX     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_fwd_engine_if.slave      bus,
    input  logic [NUM_PORTS-1:0] mask_port,
    input  logic                 age_tick,
    input  logic                 flush,
    output logic                 table_full
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IDX_W  = $clog2(TABLE_DEPTH);
    localparam int AGE_W  = $clog2(AGE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_LEARN, S_RESP} state_t;

    state_t                 state;
    logic [TABLE_DEPTH-1:0] tbl_valid;
    logic [47:0]            tbl_mac  [TABLE_DEPTH];
    logic [PORT_W-1:0]      tbl_port [TABLE_DEPTH];
    logic [AGE_W-1:0]       tbl_age  [TABLE_DEPTH];
    logic [IDX_W-1:0]       rep_ptr;

    logic [47:0]            lat_src;
    logic [47:0]            lat_dst;
    logic [PORT_W-1:0]      lat_port;
    logic                   lat_fv;
    logic                   src_hit, dst_hit;
    logic [IDX_W-1:0]       src_idx, dst_idx;
    logic                   rsp_valid_q;
    logic [NUM_PORTS-1:0]   rsp_mask_q;

    logic                   src_hit_c, dst_hit_c, free_c;
    logic [IDX_W-1:0]       src_idx_c, dst_idx_c, free_idx_c;
    logic                   wr_en, use_ptr;
    logic [IDX_W-1:0]       wr_idx;
    logic [NUM_PORTS-1:0]   in_bit, out_bit, mask_c;

    assign bus.req_ready     = (state == S_IDLE) && !rst;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_port_mask = rsp_mask_q;

    // Descending scan so the lowest matching / free index is the one left standing.
    always_comb begin
        src_hit_c  = 1'b0;
        dst_hit_c  = 1'b0;
        free_c     = 1'b0;
        src_idx_c  = '0;
        dst_idx_c  = '0;
        free_idx_c = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (tbl_valid[i] && tbl_mac[i] == lat_src) begin
                src_hit_c = 1'b1;
                src_idx_c = IDX_W'(i);
            end
            if (tbl_valid[i] && tbl_mac[i] == lat_dst) begin
                dst_hit_c = 1'b1;
                dst_idx_c = IDX_W'(i);
            end
            if (!tbl_valid[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        wr_en   = (state == S_LEARN) && lat_fv;
        use_ptr = !src_hit && !free_c;
        wr_idx  = src_hit ? src_idx : (free_c ? free_idx_c : rep_ptr);
    end

    // Decision uses hit results captured in LOOKUP, i.e. the table before this frame learns.
    always_comb begin
        in_bit  = NUM_PORTS'(1) << lat_port;
        out_bit = NUM_PORTS'(1) << tbl_port[dst_idx];
        if (!lat_fv)
            mask_c = '0;
        else if (lat_dst[40] || !dst_hit)
            mask_c = ~in_bit & ~mask_port;
        else if (tbl_port[dst_idx] == lat_port)
            mask_c = '0;
        else
            mask_c = out_bit & ~mask_port;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tbl_valid   <= '0;
            rep_ptr     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mask_q  <= '0;
            table_full  <= 1'b0;
        end else begin
            table_full <= &tbl_valid;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_src  <= bus.req_src_mac;
                        lat_dst  <= bus.req_dst_mac;
                        lat_port <= bus.req_port;
                        lat_fv   <= bus.req_frame_valid;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    src_hit <= src_hit_c;
                    src_idx <= src_idx_c;
                    dst_hit <= dst_hit_c;
                    dst_idx <= dst_idx_c;
                    state   <= S_LEARN;
                end
                S_LEARN: begin
                    rsp_mask_q  <= mask_c;
                    rsp_valid_q <= 1'b1;
                    if (wr_en && use_ptr)
                        rep_ptr <= rep_ptr + 1'b1;
                    state <= S_RESP;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase

            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (flush) begin
                    tbl_valid[i] <= 1'b0;
                end else if (wr_en && wr_idx == IDX_W'(i)) begin
                    tbl_valid[i] <= 1'b1;
                    tbl_mac[i]   <= lat_src;
                    tbl_port[i]  <= lat_port;
                    tbl_age[i]   <= AGE_W'(AGE_MAX);
                end else if (age_tick && tbl_valid[i]) begin
                    if (tbl_age[i] == AGE_W'(1))
                        tbl_valid[i] <= 1'b0;
                    else
                        tbl_age[i] <= tbl_age[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_fwd_engine.sv
// tb/tb_mac_fwd_engine.sv - scoreboard bench for mac_fwd_engine against a table-level reference model
module tb_mac_fwd_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mask_port = 4'h0;
    logic       age_tick = 1'b0;
    logic       flush = 1'b0;
    logic       table_full;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rr_mode = 1;

    typedef struct {
        logic [3:0] mask;
        int         acc;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;
    localparam logic [47:0] MAC_C = 48'h02_00_00_00_00_03;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    mac_fwd_engine_if #(.NUM_PORTS(4)) bus ();

    mac_fwd_engine #(.NUM_PORTS(4), .TABLE_DEPTH(8), .AGE_MAX(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mask_port(mask_port),
        .age_tick(age_tick), .flush(flush), .table_full(table_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference table: slot-indexed entries with a countdown lifetime.
    bit          m_valid [8];
    logic [47:0] m_mac   [8];
    int          m_port  [8];
    int          m_age   [8];
    int          m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_ptr = 0;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < 8; i++)
            if (m_valid[i]) begin
                if (m_age[i] == 1) m_valid[i] = 0;
                else m_age[i]--;
            end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic logic [3:0] model_req(logic [47:0] s, logic [47:0] d, int p, bit fv, logic [3:0] mp);
        int sh = -1, dh = -1, slot = -1;
        logic [3:0] m;
        if (!fv) return 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_mac[i] == s && sh < 0) sh = i;
            if (m_valid[i] && m_mac[i] == d && dh < 0) dh = i;
            if (!m_valid[i] && slot < 0) slot = i;
        end
        if (d[40] || dh < 0) m = 4'hF & ~(4'h1 << p) & ~mp;
        else if (m_port[dh] == p) m = 4'h0;
        else m = (4'h1 << m_port[dh]) & ~mp;
        if (sh >= 0) slot = sh;
        else if (slot < 0) begin
            slot = m_ptr;
            m_ptr = (m_ptr + 1) % 8;
        end
        m_valid[slot] = 1;
        m_mac[slot]   = s;
        m_port[slot]  = p;
        m_age[slot]   = 3;
        return m;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic send(input logic [47:0] s, input logic [47:0] d, input int p, input bit fv,
                        input logic [3:0] mp, input int want, input bit push = 1);
        exp_t e;
        logic [3:0] m;
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            return;
        end
        bus.req_src_mac = s;
        bus.req_dst_mac = d;
        bus.req_port = 2'(p);
        bus.req_frame_valid = fv;
        mask_port = mp;
        bus.req_valid = 1'b1;
        if (push) begin
            m = model_req(s, d, p, fv, mp);
            e.mask = (want >= 0) ? 4'(want) : m;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("idle_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic pulse_tick();
        wait_idle();
        @(posedge clk); #1 age_tick = 1'b1;
        @(posedge clk); #1 age_tick = 1'b0;
        model_tick();
    endtask

    task automatic pulse_flush();
        wait_idle();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_reset_valid();
    endtask

    function automatic void model_reset_valid();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
    endfunction

    task automatic check_full(input string nm);
        wait_idle();
        @(posedge clk);
        @(negedge clk);
        check(nm, 64'(table_full), 64'(model_count() == 8));
    endtask

    initial begin : ready_gen
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: bus.rsp_ready = ($urandom_range(0, 3) != 0);
                1: bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        bit prev_v = 0;
        logic [3:0] held = 4'h0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
                continue;
            end
            if (bus.rsp_valid) begin
                check("req_ready_in_resp", 64'(bus.req_ready), 64'(0));
                if (!prev_v) begin
                    held = bus.rsp_port_mask;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got mask %b with no request pending", bus.rsp_port_mask);
                    end else begin
                        check("latency", 64'(cyc - exp_q[0].acc), 64'(3));
                    end
                end else begin
                    check("mask_stable", 64'(bus.rsp_port_mask), 64'(held));
                end
                if (bus.rsp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_mask", 64'(bus.rsp_port_mask), 64'(e.mask));
                end
            end
            prev_v = bus.rsp_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        logic [47:0] pool [10];
        logic [47:0] s, d;
        int r, k;
        bus.req_valid = 1'b0;
        bus.req_src_mac = '0;
        bus.req_dst_mac = '0;
        bus.req_port = '0;
        bus.req_frame_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) pool[i] = 48'h02_00_00_00_10_00 + 48'(i);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_mask", 64'(bus.rsp_port_mask), 64'(0));
        check("rst_table_full", 64'(table_full), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));

        // basic learn / lookup / filter / broadcast
        send(MAC_A, MAC_B, 0, 1, 4'h0, 4'b1110);
        check_full("full_after_first");
        send(MAC_B, MAC_A, 2, 1, 4'h0, 4'b0001);
        send(MAC_A, MAC_A, 0, 1, 4'h0, 4'b0000);
        send(MAC_B, BCAST, 1, 1, 4'b1000, 4'b0101);
        // station move
        send(MAC_A, MAC_B, 3, 1, 4'h0, 4'b0010);
        send(MAC_B, MAC_A, 1, 1, 4'h0, 4'b1000);

        // aging
        pulse_flush();
        send(MAC_A, MAC_B, 0, 1, 4'h0, 4'b1110);
        repeat (3) pulse_tick();
        send(MAC_C, MAC_A, 1, 1, 4'h0, 4'b1101);
        send(MAC_A, MAC_C, 0, 1, 4'h0, 4'b0010);
        repeat (2) pulse_tick();
        send(MAC_A, MAC_C, 0, 1, 4'h0, 4'b0010);
        send(MAC_C, MAC_A, 1, 1, 4'h0, 4'b0001);

        // stalled response: stable mask, flush and mask_port changes do not disturb it
        wait_idle();
        rr_mode = 2;
        send(MAC_A, MAC_C, 0, 1, 4'h0, 4'b0010);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stall_rsp_seen", 64'(bus.rsp_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.rsp_valid), 64'(1));
            check("stall_req_ready", 64'(bus.req_ready), 64'(0));
            if (i == 1) mask_port = 4'b0010;
            if (i == 2) flush = 1'b1;
            if (i == 3) flush = 1'b0;
        end
        model_reset_valid();
        rr_mode = 1;
        send(MAC_C, MAC_A, 2, 1, 4'h0, 4'b1011);

        // fill the table, then replacement pointer and discarded frames
        pulse_flush();
        for (int i = 0; i < 8; i++) send(pool[i], BCAST, i % 4, 1, 4'h0, -1);
        check_full("full_after_8");
        send(pool[8], pool[5], 0, 1, 4'h0, 4'b0010);
        send(pool[9], pool[0], 0, 1, 4'h0, 4'b1110);
        send(pool[8], pool[1], 0, 1, 4'h0, 4'b1110);
        send(pool[8], pool[2], 0, 1, 4'h0, 4'b0100);
        send(MAC_C, pool[2], 3, 0, 4'h0, 4'b0000);
        send(pool[8], MAC_C, 0, 1, 4'h0, 4'b1110);
        send(pool[8], pool[2], 0, 1, 4'h0, 4'b0100);
        check_full("full_after_replace");

        // randomized traffic against the model
        rr_mode = 0;
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 10) pulse_tick();
            else if (r < 13) pulse_flush();
            else begin
                s = pool[$urandom_range(0, 9)];
                case ($urandom_range(0, 9))
                    0: d = BCAST;
                    1: d = 48'h01_00_5E_00_00_01;
                    default: d = pool[$urandom_range(0, 9)];
                endcase
                send(s, d, $urandom_range(0, 3), $urandom_range(0, 9) != 0,
                     ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0, -1);
            end
            if (it % 25 == 24) check_full("full_random");
        end
        rr_mode = 1;
        wait_idle();

        // reset while the request sits in S_LEARN
        send(MAC_A, MAC_B, 0, 1, 4'h0, -1, 0);
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("midrst_mask", 64'(bus.rsp_port_mask), 64'(0));
            check("midrst_table_full", 64'(table_full), 64'(0));
            check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 64'(bus.req_ready), 64'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        send(MAC_B, MAC_A, 1, 1, 4'h0, 4'b1101);
        send(MAC_A, MAC_B, 0, 1, 4'h0, 4'b0010);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
